seg7_scan_multi: RTL and testbench

Parametrised multiplexed seven-segment display driver with a selectable hex/decimal mode. It replaces the fixed four-digit hex-only scanner on the board-level display path that shows CPU_out halves. Decimal mode uses a sequential shift-add-3 (double-dabble) binary-to-BCD converter. Digit scan rate, digit count and input width are parameters, and the block adds leading-zero blanking, a per-digit decimal point and overflow indication.

---
 rtl/seg7_scan_multi.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_multi.sv
// Multiplexed seven-segment driver: hex or double-dabble decimal display with
// leading-zero blanking, per-digit decimal point and an overflow dash pattern.
module seg7_scan_multi #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16,
  parameter int DIV    = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  x,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        a_to_g,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic              busy
);
  localparam int NB = 4 * DIGITS;
  localparam int XW = (WIDTH > NB) ? WIDTH : NB;
  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] SHIFTS    = CW'(WIDTH);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // Hex path: zero-extend so narrow inputs still fill every digit.
  logic [XW-1:0] x_ext;
  logic [NB-1:0] hex_val;
  logic          hex_ovf;

  assign x_ext   = XW'(x);
  assign hex_val = x_ext[NB-1:0];
  assign hex_ovf = |(x_ext >> NB);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [NB-1:0]    bcd_q, bcd_nxt, bcd_adj;
  logic             sticky_q, sticky_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;

  // NOTE: every signal driven from always_comb gets a default first so no path infers a latch.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_nxt  = state;
    bin_nxt    = bin_q;
    bcd_nxt    = bcd_q;
    sticky_nxt = sticky_q;
    cnt_nxt    = cnt_q;
    if (!mode) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          bin_nxt    = x;
          bcd_nxt    = '0;
          sticky_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = SHIFT;
        end
        SHIFT: begin
          {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
          sticky_nxt         = sticky_q | bcd_adj[NB-1];
          cnt_nxt            = cnt_q + 1'b1;
          if (cnt_nxt == SHIFTS) state_nxt = DONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bin_q    <= bin_nxt;
      bcd_q    <= bcd_nxt;
      sticky_q <= sticky_nxt;
      cnt_q    <= cnt_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // The display only ever takes a finished BCD value, never a partial one.
  logic [NB-1:0] disp_q;
  logic          ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!mode) begin
      disp_q <= hex_val;
      ovf_q  <= hex_ovf;
    end else if (state == DONE) begin
      disp_q <= bcd_q;
      ovf_q  <= sticky_q;
    end
  end

  logic [PW-1:0] pre_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] upper_zero;
  logic              lz_acc;
  logic [3:0]        nib;
  logic [6:0]        seg_sel;

  always_comb begin
    upper_zero = '0;
    lz_acc     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_acc        = lz_acc & (disp_q[4*i +: 4] == 4'd0);
      upper_zero[i] = lz_acc;
    end
    nib = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)
      seg_sel = SEG_DASH;
    else if (blank_lz && (idx_q != '0) && upper_zero[idx_q])
      seg_sel = SEG_BLANK;
    else
      seg_sel = glyph(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_to_g <= SEG_BLANK;
      an     <= '1;
      dp     <= 1'b1;
    end else begin
      a_to_g <= seg_sel;
      an     <= ~(DIGITS'(1) << idx_q);
      dp     <= ~dp_mask[idx_q];
    end
  end

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Bench for seg7_scan_multi: expected display frames come from an arithmetic
// model and are checked by a monitor as each digit is presented.
`timescale 1ns/1ps
module tb_seg7_scan_multi;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;
  localparam int DIV    = 4;
  localparam int SCAN   = DIGITS * DIV;
  localparam int SETTLE = 2 * (WIDTH + 2) + 8;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  x = '1;
  logic              mode = 1'b0;
  logic              blank_lz = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic [6:0]        a_to_g;
  logic [DIGITS-1:0] an;
  logic              dp;
  logic              busy;

  seg7_scan_multi #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .mode(mode), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .a_to_g(a_to_g), .an(an), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct packed {
    logic [DIGITS-1:0][6:0] seg;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      seen;
  } frame_t;

  frame_t sb_q [$];

  // What a steady display should look like, from place-value arithmetic.
  function automatic frame_t model(input logic [WIDTH-1:0] xv, input logic m,
                                   input logic blz, input logic [DIGITS-1:0] dpm);
    frame_t f;
    longint unsigned base  = m ? 64'd10 : 64'd16;
    longint unsigned span  = 1;
    longint unsigned place = 1;
    longint unsigned v     = 64'(xv);
    longint unsigned shown;
    longint unsigned digit;
    bit ovf;
    f = '0;
    for (int i = 0; i < DIGITS; i++) span = span * base;
    ovf   = (v >= span);
    shown = v % span;
    for (int i = 0; i < DIGITS; i++) begin
      digit = (shown / place) % base;
      if (ovf)                               f.seg[i] = DASH;
      else if (blz && i > 0 && shown < place) f.seg[i] = BLANK;
      else                                    f.seg[i] = glyph_tab[4'(digit)];
      f.dp[i] = ~dpm[i];
      place   = place * base;
    end
    return f;
  endfunction

  function automatic int digit_of(input logic [DIGITS-1:0] a);
    for (int i = 0; i < DIGITS; i++)
      if (a[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [DIGITS-1:0] next_an(input logic [DIGITS-1:0] a);
    int p = digit_of(a);
    return ~(DIGITS'(1) << ((p + 1) % DIGITS));
  endfunction

  task automatic present(input logic [DIGITS-1:0] a);
    int d = digit_of(a);
    frame_t f;
    if (d < 0 || sb_q.size() == 0) return;
    f = sb_q[0];
    if (f.seen[d]) return;
    check($sformatf("segments digit %0d", d), 32'(a_to_g), 32'(f.seg[d]));
    check($sformatf("dp digit %0d", d), 32'(dp), 32'(f.dp[d]));
    f.seen[d] = 1'b1;
    sb_q[0]   = f;
    if (&f.seen) void'(sb_q.pop_front());
  endtask

  // Monitor: every new digit presentation checks hold time, scan order and the pending frame.
  logic [DIGITS-1:0] prev_an = '1;
  int                hold = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_an = '1;
      hold    = 0;
    end else if (an !== prev_an) begin
      if (prev_an !== '1) begin
        check("digit hold cycles", 32'(hold), 32'(DIV));
        check("scan order", 32'(an), 32'(next_an(prev_an)));
      end
      present(an);
      prev_an = an;
      hold    = 1;
    end else begin
      hold++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [WIDTH-1:0] xv, input logic m,
                       input logic blz, input logic [DIGITS-1:0] dpm);
    int n = 0;
    x = xv; mode = m; blank_lz = blz; dp_mask = dpm;
    tick(SETTLE);
    sb_q.push_back(model(xv, m, blz, dpm));
    while (sb_q.size() != 0 && n < 3 * SCAN) begin
      tick(1);
      n++;
    end
    check("frame drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic wait_busy(input logic lvl, output bit ok);
    int n = 0;
    while (busy !== lvl && n < 64) begin
      tick(1);
      n++;
    end
    ok = (busy === lvl);
  endtask

  task automatic reach_shift8();
    bit ok;
    wait_busy(1'b0, ok);
    check("busy low seen", 32'(ok), 32'd1);
    wait_busy(1'b1, ok);
    check("busy high seen", 32'(ok), 32'd1);
    tick(7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    bit ok;
    logic [WIDTH-1:0] xv;

    // Reset held for three cycles with all-ones input.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset a_to_g", 32'(a_to_g), 32'h7F);
      check("reset an", 32'(an), 32'hF);
      check("reset dp", 32'(dp), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
    end
    x = '0;
    rst_n = 1'b1;
    tick(1);
    check("first digit after release", 32'(an), 32'b1110);

    apply(16'h3C1F, 1'b0, 1'b0, 4'b0010);

    // Decimal conversion period.
    x = 16'd1234; mode = 1'b1;
    wait_busy(1'b0, ok);
    wait_busy(1'b1, ok);
    check("busy rise", 32'(ok), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 64) begin tick(1); n++; end
    check("busy high cycles", 32'(n), 32'(WIDTH + 1));
    n = 0;
    while (busy === 1'b0 && n < 64) begin tick(1); n++; end
    check("busy low cycles", 32'(n), 32'd1);
    apply(16'd1234, 1'b1, 1'b0, 4'b0000);

    apply(16'd65535, 1'b1, 1'b0, 4'b1001);
    apply(16'd9999,  1'b1, 1'b0, 4'b0000);
    apply(16'h0005,  1'b0, 1'b1, 4'b0000);
    apply(16'h0000,  1'b0, 1'b1, 4'b0100);
    apply(16'd7,     1'b1, 1'b1, 4'b1000);
    apply(16'd10000, 1'b1, 1'b1, 4'b0000);

    // Abort: decimal 4369 on display, switch to hex mid-conversion.
    apply(16'h1111, 1'b1, 1'b0, 4'b0101);
    reach_shift8();
    mode = 1'b0;
    tick(1);
    check("abort busy", 32'(busy), 32'd0);
    tick(1);
    check("abort hex glyph", 32'(a_to_g), 32'(glyph_tab[1]));
    bad = 0;
    for (int i = 0; i < SCAN + 2 * WIDTH; i++) begin
      tick(1);
      if (a_to_g !== glyph_tab[1] || busy !== 1'b0) bad++;
    end
    check("abort no stale bcd", 32'(bad), 32'd0);

    // Reset pulsed mid-conversion.
    x = 16'd1234; mode = 1'b1;
    reach_shift8();
    rst_n = 1'b0;
    tick(1);
    check("midconv reset a_to_g", 32'(a_to_g), 32'h7F);
    check("midconv reset an", 32'(an), 32'hF);
    check("midconv reset dp", 32'(dp), 32'd1);
    check("midconv reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("midconv release an", 32'(an), 32'b1110);
    check("midconv release seg", 32'(a_to_g), 32'(glyph_tab[0]));
    apply(16'd1234, 1'b1, 1'b0, 4'b0001);

    // Randomised frames across modes, value ranges, blanking and dp masks.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       xv = 16'($urandom_range(0, 15));
        1:       xv = 16'($urandom_range(0, 999));
        2:       xv = 16'($urandom_range(10000, 65535));
        default: xv = 16'($urandom());
      endcase
      apply(xv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
